tomasulo_rs: RTL
================

# tomasulo_rs

Parametrised reservation station for the Tomasulo out-of-order pipeline, generalising the single-CDB, fixed-width dispatch/issue formats into a configurable-depth buffer. It sits between the dispatch stage and one functional unit (arith, logic or mpy). It accepts dispatched instructions whose operands are values or pending tags, and snoops CDB_N common data buses to capture results. Ready entries issue to the unit in oldest-first order over a valid/ready handshake.

## Interface
- N, 4: reservation-station entries (≥2)
- CDB_N, 2: CDB channels snooped per cycle (≥1)
- W, 32: operand word width
- TAG_W, 5: tag width (≤W)
- OP_W, 4: opcode width
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all entries and output stage
- dispatch_vld  in  1  dispatch request
- dispatch_rdy  out  1  entry available (= !full && !rst)
- dispatch_op  in  OP_W  opcode
- dispatch_tag  in  TAG_W  destination tag
- dispatch_busy  in  2  per-operand pending flag
- dispatch_oprand  in  2*W  operand i at [i*W +: W]; if busy, tag in low TAG_W bits
- cdb_vld  in  CDB_N  broadcast valid per channel
- cdb_tag  in  CDB_N*TAG_W  broadcast tags
- cdb_wdata  in  CDB_N*W  broadcast data
- issue_vld  out  1  output stage holds an instruction
- issue_rdy  in  1  unit accepts
- issue_op  out  OP_W  opcode
- issue_tag  out  TAG_W  destination tag
- issue_rdata  out  2*W  resolved operands, same packing as dispatch_oprand
- occupancy  out  $clog2(N+1)  valid RS entries (output stage excluded)

## Operation
- Entry fields: vld, op, tag, per-operand busy + value/tag, age. Age is strict; older entries were dispatched earlier.
- Dispatch fires on dispatch_vld && dispatch_rdy. The entry is written into the lowest-index free slot.
- Same-cycle capture (always on): a busy dispatch operand whose tag matches a valid CDB channel in the dispatch cycle is stored as ready with that data.
- Wakeup: each valid entry's busy operand compares against all CDB channels every cycle. On a match it captures cdb_wdata and clears busy at the edge.
- If multiple channels match one operand, the lowest channel index wins. This is a protocol violation, but the result is deterministic.
- Ready means vld and both operands not busy.
- Output stage: one register feeding issue_*. It loads when (empty || issue_rdy) and a ready entry exists. It takes the oldest ready entry, and that entry is freed at the same edge.
- issue_* are stable while issue_vld && !issue_rdy. Entries that become older-ready meanwhile do not displace the held instruction.
- Full: occupancy==N makes dispatch_rdy=0. dispatch_rdy does not look ahead to a same-cycle free.
- Simultaneous dispatch and issue-free: occupancy is unchanged.
- flush: all entries and the output stage are invalidated at the edge. Dispatch, CDB capture and issue acceptance in the flush cycle are ignored. The next cycle has occupancy=0 and issue_vld=0.
- Reset values: issue_vld=0, issue_op/tag/rdata=0, occupancy=0, all entry vld=0. dispatch_rdy=0 while rst is high and 1 on the first cycle after.
- rst asserted mid-operation behaves like flush and also clears age state.

## Timing
- Dispatch in cycle t with all operands ready (stored or captured): entry valid in t+1, issue_vld in t+2 at earliest.
- CDB broadcast in cycle t wakes a waiting entry. If it is the oldest ready entry, issue_vld follows in t+2.
- Back-to-back: with issue_rdy held high, one issue per cycle is sustained while ready entries exist.
- occupancy and dispatch_rdy are registered-state functions. They do not combinationally depend on issue_rdy or dispatch_vld.

## Configuration
- TOMASULO_RS_BYPASS_EN defined: a dispatch that is fully ready (after same-cycle capture) loads the output stage directly, bypassing the RS, when all three hold:
  - the output stage is empty or being accepted;
  - no RS entry is ready;
  - dispatch is otherwise allowed.
  In that case issue_vld rises in t+1 and occupancy does not increment.
- Not defined: every dispatch occupies an entry, and dispatch-to-issue is ≥2 cycles.

## Test plan
- Reset, then dispatch op=4'b0101 tag=3, operands 10 and 20 ready, issue_rdy=1 → issue_vld in cycle t+2 (t+1 with bypass), rdata={20,10}, tag=3, occupancy returns to 0.
- Dispatch tag=7 waiting on tag 2; two cycles later cdb_vld[1]=1, tag=2, wdata=0xDEAD → issue two cycles after the broadcast with operand 0xDEAD.
- Dispatch with an operand busy on tag 4 while cdb channel 0 broadcasts tag 4 = 0x55 in the same cycle → entry ready, issues with 0x55 and is never stranded.
- Fill N=4 entries blocked on tags 1..4, then broadcast tags 4,3 together on channels 0/1 → dispatch_rdy=0 while full; the entry waiting on 3 issues before the one waiting on 4 (oldest-first).
- Hold issue_rdy=0 with issue_vld=1, then make an older entry ready → issue_* unchanged until accepted.
- Assert flush with 3 entries and a held output → next cycle issue_vld=0 and occupancy=0; stale tags broadcast afterwards produce no issue.

Source files
------------

// File: rtl/tomasulo_rs_if.sv
// Dispatch, CDB snoop and issue signal bundle for tomasulo_rs.
// The master modport drives dispatch/CDB/issue_rdy; the slave modport is the reservation station.
interface tomasulo_rs_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned CDB_N = 2,
  parameter int unsigned W     = 32,
  parameter int unsigned TAG_W = 5,
  parameter int unsigned OP_W  = 4
);
  localparam int unsigned OccW = $clog2(N + 1);

  logic                   flush;
  logic                   dispatch_vld;
  logic                   dispatch_rdy;
  logic [OP_W-1:0]        dispatch_op;
  logic [TAG_W-1:0]       dispatch_tag;
  logic [1:0]             dispatch_busy;
  logic [2*W-1:0]         dispatch_oprand;
  logic [CDB_N-1:0]       cdb_vld;
  logic [CDB_N*TAG_W-1:0] cdb_tag;
  logic [CDB_N*W-1:0]     cdb_wdata;
  logic                   issue_vld;
  logic                   issue_rdy;
  logic [OP_W-1:0]        issue_op;
  logic [TAG_W-1:0]       issue_tag;
  logic [2*W-1:0]         issue_rdata;
  logic [OccW-1:0]        occupancy;

  modport master (
    output flush, dispatch_vld, dispatch_op, dispatch_tag, dispatch_busy, dispatch_oprand,
    output cdb_vld, cdb_tag, cdb_wdata, issue_rdy,
    input  dispatch_rdy, issue_vld, issue_op, issue_tag, issue_rdata, occupancy
  );

  modport slave (
    input  flush, dispatch_vld, dispatch_op, dispatch_tag, dispatch_busy, dispatch_oprand,
    input  cdb_vld, cdb_tag, cdb_wdata, issue_rdy,
    output dispatch_rdy, issue_vld, issue_op, issue_tag, issue_rdata, occupancy
  );
endinterface

// File: rtl/tomasulo_rs.sv
// Reservation station: N entries snooping CDB_N result buses, oldest-ready issue via one output
// register. Define TOMASULO_RS_BYPASS_EN to let a fully ready dispatch load the output directly.
module tomasulo_rs #(
  parameter int unsigned N     = 4,
  parameter int unsigned CDB_N = 2,
  parameter int unsigned W     = 32,
  parameter int unsigned TAG_W = 5,
  parameter int unsigned OP_W  = 4
) (
  input logic          clk,
  input logic          rst,
  tomasulo_rs_if.slave bus
);
  localparam int unsigned OccW = $clog2(N + 1);

  typedef struct packed {
    logic                vld;
    logic [OP_W-1:0]     op;
    logic [TAG_W-1:0]    tag;
    logic [1:0]          busy;
    logic [1:0][W-1:0]   val;  // busy operand keeps its pending tag in the low TAG_W bits
  } entry_t;

  entry_t [N-1:0]        ent_q, ent_d;
  logic [N-1:0][N-1:0]   older_q, older_d;  // older_q[i][j]: entry i was dispatched before j
  logic                  out_vld_q, out_vld_d;
  logic [OP_W-1:0]       out_op_q, out_op_d;
  logic [TAG_W-1:0]      out_tag_q, out_tag_d;
  logic [1:0][W-1:0]     out_val_q, out_val_d;

  logic [N-1:0]          rdy, sel_oh, free_oh;
  logic                  any_rdy, free_found, full;
  entry_t                sel_ent;
  logic [OccW-1:0]       occ;
  logic [1:0]            d_busy;
  logic [1:0][W-1:0]     d_val;
  logic [W:0]            hit;
  logic                  disp_fire, out_free, bypass;

  // Returns {match, data}; scanning downwards lets the lowest matching channel win.
  function automatic logic [W:0] snoop(input logic [TAG_W-1:0] t);
    logic [W:0] r;
    r = '0;
    for (int c = int'(CDB_N) - 1; c >= 0; c--) begin
      if (bus.cdb_vld[c] && bus.cdb_tag[c*TAG_W +: TAG_W] == t) begin
        r = {1'b1, bus.cdb_wdata[c*W +: W]};
      end
    end
    return r;
  endfunction

  always_comb begin
    occ        = '0;
    rdy        = '0;
    free_oh    = '0;
    free_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      occ    = occ + OccW'(ent_q[i].vld);
      rdy[i] = ent_q[i].vld && (ent_q[i].busy == 2'b00);
      if (!ent_q[i].vld && !free_found) begin
        free_oh[i] = 1'b1;
        free_found = 1'b1;
      end
    end
    any_rdy = |rdy;
    full    = (occ == OccW'(N));
  end

  always_comb begin
    sel_oh  = '0;
    sel_ent = '0;
    for (int i = 0; i < N; i++) begin
      sel_oh[i] = rdy[i];
      for (int j = 0; j < N; j++) begin
        if (j != i && rdy[j] && older_q[j][i]) sel_oh[i] = 1'b0;
      end
      if (sel_oh[i]) sel_ent = ent_q[i];
    end
  end

  // Same-cycle capture of dispatch operands.
  always_comb begin
    d_busy = bus.dispatch_busy;
    d_val  = bus.dispatch_oprand;
    for (int k = 0; k < 2; k++) begin
      if (bus.dispatch_busy[k]) begin
        if (snoop(d_val[k][TAG_W-1:0]) != '0) begin
          d_busy[k] = 1'b0;
          d_val[k]  = snoop(bus.dispatch_oprand[k*W +: TAG_W]) & {1'b0, {W{1'b1}}};
        end
      end
    end
  end

  assign disp_fire = bus.dispatch_vld && bus.dispatch_rdy;
  assign out_free  = !out_vld_q || bus.issue_rdy;

`ifdef TOMASULO_RS_BYPASS_EN
  assign bypass = disp_fire && (d_busy == 2'b00) && out_free && !any_rdy;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    ent_d     = ent_q;
    older_d   = older_q;
    out_vld_d = out_vld_q;
    out_op_d  = out_op_q;
    out_tag_d = out_tag_q;
    out_val_d = out_val_q;
    hit       = '0;

    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (ent_q[i].vld && ent_q[i].busy[k]) begin
          hit = snoop(ent_q[i].val[k][TAG_W-1:0]);
          if (hit[W]) begin
            ent_d[i].busy[k] = 1'b0;
            ent_d[i].val[k]  = hit[W-1:0];
          end
        end
      end
    end

    if (out_free) begin
      if (any_rdy) begin
        out_vld_d = 1'b1;
        out_op_d  = sel_ent.op;
        out_tag_d = sel_ent.tag;
        out_val_d = sel_ent.val;
        for (int i = 0; i < N; i++) begin
          if (sel_oh[i]) ent_d[i].vld = 1'b0;
        end
      end else if (bypass) begin
        out_vld_d = 1'b1;
        out_op_d  = bus.dispatch_op;
        out_tag_d = bus.dispatch_tag;
        out_val_d = d_val;
      end else begin
        out_vld_d = 1'b0;
      end
    end

    if (disp_fire && !bypass) begin
      for (int i = 0; i < N; i++) begin
        if (free_oh[i]) begin
          ent_d[i].vld  = 1'b1;
          ent_d[i].op   = bus.dispatch_op;
          ent_d[i].tag  = bus.dispatch_tag;
          ent_d[i].busy = d_busy;
          ent_d[i].val  = d_val;
          for (int j = 0; j < N; j++) begin
            older_d[i][j] = 1'b0;
            older_d[j][i] = ent_q[j].vld;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      ent_q     <= '0;
      out_vld_q <= 1'b0;
      out_op_q  <= '0;
      out_tag_q <= '0;
      out_val_q <= '0;
      if (rst) older_q <= '0;
    end else begin
      ent_q     <= ent_d;
      older_q   <= older_d;
      out_vld_q <= out_vld_d;
      out_op_q  <= out_op_d;
      out_tag_q <= out_tag_d;
      out_val_q <= out_val_d;
    end
  end

  assign bus.dispatch_rdy = !full && !rst;
  assign bus.occupancy    = occ;
  assign bus.issue_vld    = out_vld_q;
  assign bus.issue_op     = out_op_q;
  assign bus.issue_tag    = out_tag_q;
  assign bus.issue_rdata  = out_val_q;

endmodule
